l1inv_seq: RTL and testbench
============================

Name: l1inv_seq

Overview:
- Downstream of the L1 shadow directory. Each directory query produces a primary invalidation vector and a secondary one (second D-line of an ifill); this block turns them into CPX eviction/invalidation packets.
- It sends each packet only to the CPUs whose L1 copies hit, collects every per-CPU grant, and reports completion to the bridge FSM.
- It sits between the directory outputs and the CPX return mux.

Parameters:
- TIMEOUT, 1023, grant-wait cycles before err_timeout asserts (10-bit counter).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; directory vectors valid this cycle
- dual  in  1  second vector present (ifill)
- addr  in  8  line address bits [11:4] of the transaction
- inval_vect0  in  112  primary invalidation vector
- inval_vect1  in  112  secondary invalidation vector
- cpx_pkt  out  145  packet to CPX mux
- cpx_req  out  2  per-CPU request, bit n = CPU n
- cpx_grant  in  2  per-CPU grant, one-cycle pulse
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, sequence complete
- pkt_cnt  out  2  packets sent in the last sequence (0..2)
- err_overrun  out  1  sticky: start while busy
- err_timeout  out  1  sticky: grant wait exceeded TIMEOUT

Behaviour:
- Reset (async, immediate): all outputs 0, FSM IDLE, latches and counters cleared. Reset mid-sequence aborts without emitting done.
- Hit masks:
  - CPU0 = bits {0,1,32,56,57,88}.
  - CPU1 = bits {4,5,35,60,61,91}.
  - cpuN_hit(v) = OR of v over the CPUn mask.
- Packet layout for vector v:
  - [144]=1
  - [143:140]=4'b0011
  - [139:128]=0
  - [127:120]=0
  - [119:112]=addr_l
  - [111:0]=v
- IDLE:
  - On start: latch both vectors, dual and addr into *_l; clear pkt_cnt; set busy; go to CHK0.
  - start while not IDLE: ignored, err_overrun set.
- CHK0:
  - hitmask0 = {cpu1_hit(v0_l), cpu0_hit(v0_l)}.
  - If nonzero: load cpx_req=hitmask0, drive packet(v0_l), go to WAIT0.
  - Else go to CHK1.
- WAIT0:
  - cpx_pkt is held stable.
  - Each cpx_grant[n] with cpx_req[n]=1 clears cpx_req[n] the same edge. Grants on unrequested bits are ignored.
  - When cpx_req becomes 0: pkt_cnt++, clear the timeout counter, go to CHK1.
- CHK1 / WAIT1: same as CHK0 / WAIT0 using v1_l, but only if dual_l=1; otherwise go to FIN.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- Latency:
  - No hits: start to done = 3 cycles (IDLE→CHK0→CHK1→FIN).
  - Each sent packet adds (grant cycles + 1).
- cpx_pkt is 0 whenever cpx_req==0.
- Timeout:
  - A 10-bit counter increments each WAIT cycle and clears on state exit.
  - At the count equal to TIMEOUT: err_timeout=1 (sticky), force cpx_req=0, count the packet as not sent, and proceed as if all grants were received.
- A grant arriving in the same cycle as the timeout takes priority: the packet counts as sent and no error is raised.
- Both grants in one cycle are legal.
- Errors clear only on reset.

Test Plan:
- v0 bit0=1 only, dual=0, grant[0] 2 cycles after request → exactly one packet:
  - cpx_req=2'b01, cpx_pkt[111:0]=v0, [143:140]=4'b0011.
  - done follows; pkt_cnt=1.
- v0 bits 0 and 60 set → cpx_req=2'b11:
  - grant[1] first: req becomes 2'b01, packet unchanged.
  - grant[0] later: req becomes 0, advance.
- dual=1, v0 has no hits, v1 bit35 set → only one packet, with cpx_req=2'b10, payload v1; pkt_cnt=1; no-hit stage costs 1 cycle.
- Vectors all zero → done 3 cycles after start, cpx_req never asserted, pkt_cnt=0.
- TIMEOUT=8 and no grant → after 8 WAIT cycles, err_timeout=1, req=0, done asserts, pkt_cnt=0.
- start while busy → err_overrun=1, current sequence unaffected.
- Reset asserted during WAIT0 → outputs 0 immediately, no done.

Source files
------------

// File: rtl/l1inv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : l1inv_seq
//  Purpose  : L1 invalidation sequencer. Takes the primary and (for ifills)
//             secondary invalidation vectors produced by the L1 shadow
//             directory and turns them into CPX eviction/invalidation
//             packets. Each packet goes only to the CPUs whose L1 copies hit.
//             The block collects the per-CPU grants and signals completion
//             to the bridge FSM.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1    system clock
//    reset        in   1    asynchronous, active-high reset
//    start        in   1    one-cycle pulse, directory vectors valid
//    dual         in   1    secondary vector present (ifill)
//    addr         in   8    line address bits [11:4]
//    inval_vect0  in   112  primary invalidation vector
//    inval_vect1  in   112  secondary invalidation vector
//    cpx_pkt      out  145  packet to the CPX mux (0 while no request)
//    cpx_req      out  2    per-CPU request, bit n = CPU n
//    cpx_grant    in   2    per-CPU grant, one-cycle pulse
//    busy         out  1    sequence in progress
//    done         out  1    one-cycle pulse, sequence complete
//    pkt_cnt      out  2    packets sent in the last sequence
//    err_overrun  out  1    sticky: start seen while not idle
//    err_timeout  out  1    sticky: grant wait reached TIMEOUT
// ============================================================================
module l1inv_seq #(
   parameter int TIMEOUT = 1023
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           dual,
   input  logic [7:0]     addr,
   input  logic [111:0]   inval_vect0,
   input  logic [111:0]   inval_vect1,
   output logic [144:0]   cpx_pkt,
   output logic [1:0]     cpx_req,
   input  logic [1:0]     cpx_grant,
   output logic           busy,
   output logic           done,
   output logic [1:0]     pkt_cnt,
   output logic           err_overrun,
   output logic           err_timeout
);

   // Directory bit positions holding the L1 copies of each CPU.
   localparam logic [111:0] CPU0_MASK = (112'd1 << 0)  | (112'd1 << 1)  |
                                        (112'd1 << 32) | (112'd1 << 56) |
                                        (112'd1 << 57) | (112'd1 << 88);
   localparam logic [111:0] CPU1_MASK = (112'd1 << 4)  | (112'd1 << 5)  |
                                        (112'd1 << 35) | (112'd1 << 60) |
                                        (112'd1 << 61) | (112'd1 << 91);
   localparam logic [9:0]   TO_LIMIT  = 10'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHK0  = 3'd1,
      S_WAIT0 = 3'd2,
      S_CHK1  = 3'd3,
      S_WAIT1 = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   state_t         state, state_n;
   logic [111:0]   v0_l, v0_l_n;
   logic [111:0]   v1_l, v1_l_n;
   logic           dual_l, dual_l_n;
   logic [7:0]     addr_l, addr_l_n;
   logic [1:0]     req_q, req_n;
   logic [144:0]   pkt_q, pkt_n;
   logic [1:0]     cnt_q, cnt_n;
   logic [9:0]     tcnt_q, tcnt_n;
   logic           ovr_q, ovr_n;
   logic           tmo_q, tmo_n;

   // Per-CPU hit mask of a vector: bit n set when CPU n holds a copy.
   function automatic logic [1:0] hit_mask(input logic [111:0] v);
      hit_mask = {|(v & CPU1_MASK), |(v & CPU0_MASK)};
   endfunction

   function automatic logic [144:0] make_pkt(input logic [7:0]   a,
                                             input logic [111:0] v);
      make_pkt = {1'b1, 4'b0011, 12'd0, 8'd0, a, v};
   endfunction

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         v0_l   <= '0;
         v1_l   <= '0;
         dual_l <= 1'b0;
         addr_l <= '0;
         req_q  <= '0;
         pkt_q  <= '0;
         cnt_q  <= '0;
         tcnt_q <= '0;
         ovr_q  <= 1'b0;
         tmo_q  <= 1'b0;
      end else begin
         state  <= state_n;
         v0_l   <= v0_l_n;
         v1_l   <= v1_l_n;
         dual_l <= dual_l_n;
         addr_l <= addr_l_n;
         req_q  <= req_n;
         pkt_q  <= pkt_n;
         cnt_q  <= cnt_n;
         tcnt_q <= tcnt_n;
         ovr_q  <= ovr_n;
         tmo_q  <= tmo_n;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath logic
   // ------------------------------------------------------------------------
   logic [1:0] hm0, hm1, remaining;
   logic [9:0] tinc;

   always_comb begin
      state_n   = state;
      v0_l_n    = v0_l;
      v1_l_n    = v1_l;
      dual_l_n  = dual_l;
      addr_l_n  = addr_l;
      req_n     = req_q;
      pkt_n     = pkt_q;
      cnt_n     = cnt_q;
      tcnt_n    = tcnt_q;
      ovr_n     = ovr_q;
      tmo_n     = tmo_q;
      hm0       = hit_mask(v0_l);
      hm1       = hit_mask(v1_l);
      // Grants on bits that were never requested simply have no effect.
      remaining = req_q & ~cpx_grant;
      tinc      = tcnt_q + 10'd1;

      // A second start cannot be queued; it is dropped and flagged.
      if (start && (state != S_IDLE)) begin
         ovr_n = 1'b1;
      end

      case (state)
         S_IDLE: begin
            if (start) begin
               v0_l_n   = inval_vect0;
               v1_l_n   = inval_vect1;
               dual_l_n = dual;
               addr_l_n = addr;
               cnt_n    = 2'd0;
               state_n  = S_CHK0;
            end
         end

         S_CHK0: begin
            if (hm0 != 2'b00) begin
               req_n   = hm0;
               pkt_n   = make_pkt(addr_l, v0_l);
               tcnt_n  = 10'd0;
               state_n = S_WAIT0;
            end else begin
               state_n = S_CHK1;
            end
         end

         S_CHK1: begin
            if (dual_l && (hm1 != 2'b00)) begin
               req_n   = hm1;
               pkt_n   = make_pkt(addr_l, v1_l);
               tcnt_n  = 10'd0;
               state_n = S_WAIT1;
            end else begin
               state_n = S_FIN;
            end
         end

         S_WAIT0, S_WAIT1: begin
            // Completing grants win over a timeout on the same edge.
            if (remaining == 2'b00) begin
               req_n   = 2'b00;
               pkt_n   = '0;
               cnt_n   = cnt_q + 2'd1;
               tcnt_n  = 10'd0;
               state_n = (state == S_WAIT0) ? S_CHK1 : S_FIN;
            end else if (tinc == TO_LIMIT) begin
               // Abandon the packet: drop outstanding requests, not counted.
               tmo_n   = 1'b1;
               req_n   = 2'b00;
               pkt_n   = '0;
               tcnt_n  = 10'd0;
               state_n = (state == S_WAIT0) ? S_CHK1 : S_FIN;
            end else begin
               req_n  = remaining;
               tcnt_n = tinc;
            end
         end

         S_FIN: begin
            state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
            req_n   = 2'b00;
            pkt_n   = '0;
            tcnt_n  = 10'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign cpx_req     = req_q;
   assign cpx_pkt     = pkt_q;
   assign pkt_cnt     = cnt_q;
   assign err_overrun = ovr_q;
   assign err_timeout = tmo_q;
   assign done        = (state == S_FIN);
   assign busy        = (state == S_CHK0) || (state == S_WAIT0) ||
                        (state == S_CHK1) || (state == S_WAIT1);

endmodule
`default_nettype wire

// File: tb/tb_l1inv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l1inv_seq
//  Purpose  : Directed self-checking bench for l1inv_seq (TIMEOUT = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_l1inv_seq;

   logic           clk;
   logic           reset;
   logic           start;
   logic           dual;
   logic [7:0]     addr;
   logic [111:0]   inval_vect0;
   logic [111:0]   inval_vect1;
   logic [144:0]   cpx_pkt;
   logic [1:0]     cpx_req;
   logic [1:0]     cpx_grant;
   logic           busy;
   logic           done;
   logic [1:0]     pkt_cnt;
   logic           err_overrun;
   logic           err_timeout;

   int total = 0;
   int bad   = 0;

   l1inv_seq #(.TIMEOUT(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dual        (dual),
      .addr        (addr),
      .inval_vect0 (inval_vect0),
      .inval_vect1 (inval_vect1),
      .cpx_pkt     (cpx_pkt),
      .cpx_req     (cpx_req),
      .cpx_grant   (cpx_grant),
      .busy        (busy),
      .done        (done),
      .pkt_cnt     (pkt_cnt),
      .err_overrun (err_overrun),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [144:0] obs,
                      input logic [144:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [144:0] pkt(input logic [7:0] a,
                                        input logic [111:0] v);
      pkt = {1'b1, 4'b0011, 12'd0, 8'd0, a, v};
   endfunction

   logic [111:0] v0, v1;

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      dual        = 1'b0;
      addr        = 8'h00;
      inval_vect0 = '0;
      inval_vect1 = '0;
      cpx_grant   = 2'b00;
      step();
      step();
      chk("rst_req",  145'(cpx_req), 145'(2'b00));
      chk("rst_pkt",  cpx_pkt, '0);
      chk("rst_busy", 145'(busy), 145'(1'b0));
      chk("rst_done", 145'(done), 145'(1'b0));
      chk("rst_cnt",  145'(pkt_cnt), 145'(2'd0));
      reset = 1'b0;
      step();

      // ---- 1: single CPU0 packet, grant two cycles after request ----------
      v0 = 112'd1;
      v1 = 112'd1 << 4;              // would hit CPU1, but dual=0
      start = 1'b1; dual = 1'b0; addr = 8'hA5;
      inval_vect0 = v0; inval_vect1 = v1;
      step();                        // CHK0
      start = 1'b0;
      chk("t1_busy", 145'(busy), 145'(1'b1));
      chk("t1_req_chk", 145'(cpx_req), 145'(2'b00));
      step();                        // WAIT0
      chk("t1_req", 145'(cpx_req), 145'(2'b01));
      chk("t1_pkt", cpx_pkt, pkt(8'hA5, v0));
      chk("t1_type", 145'(cpx_pkt[143:140]), 145'(4'b0011));
      step();
      chk("t1_req_hold", 145'(cpx_req), 145'(2'b01));
      cpx_grant = 2'b01;
      step();                        // CHK1
      cpx_grant = 2'b00;
      chk("t1_req_clr", 145'(cpx_req), 145'(2'b00));
      chk("t1_pkt_clr", cpx_pkt, '0);
      step();                        // FIN
      chk("t1_done", 145'(done), 145'(1'b1));
      chk("t1_busy_fin", 145'(busy), 145'(1'b0));
      chk("t1_cnt", 145'(pkt_cnt), 145'(2'd1));
      step();
      chk("t1_done_low", 145'(done), 145'(1'b0));

      // ---- 2: both CPUs hit, grants arrive separately --------------------
      v0 = (112'd1 << 0) | (112'd1 << 60);
      start = 1'b1; dual = 1'b0; addr = 8'h3C; inval_vect0 = v0;
      step();
      start = 1'b0;
      step();                        // WAIT0
      chk("t2_req", 145'(cpx_req), 145'(2'b11));
      cpx_grant = 2'b10;
      step();
      cpx_grant = 2'b00;
      chk("t2_req_part", 145'(cpx_req), 145'(2'b01));
      chk("t2_pkt_hold", cpx_pkt, pkt(8'h3C, v0));
      step();
      chk("t2_req_wait", 145'(cpx_req), 145'(2'b01));
      cpx_grant = 2'b01;
      step();                        // CHK1
      cpx_grant = 2'b00;
      chk("t2_req_clr", 145'(cpx_req), 145'(2'b00));
      step();                        // FIN
      chk("t2_done", 145'(done), 145'(1'b1));
      chk("t2_cnt", 145'(pkt_cnt), 145'(2'd1));
      step();

      // ---- 3: dual, no hit on v0, CPU1 hit on v1 --------------------------
      v0 = 112'd1 << 2;              // outside both masks
      v1 = 112'd1 << 35;
      start = 1'b1; dual = 1'b1; addr = 8'h5A;
      inval_vect0 = v0; inval_vect1 = v1;
      step();                        // CHK0
      start = 1'b0;
      step();                        // CHK1
      chk("t3_req_skip", 145'(cpx_req), 145'(2'b00));
      step();                        // WAIT1
      chk("t3_req", 145'(cpx_req), 145'(2'b10));
      chk("t3_pkt", cpx_pkt, pkt(8'h5A, v1));
      cpx_grant = 2'b10;
      step();                        // FIN
      cpx_grant = 2'b00;
      chk("t3_done", 145'(done), 145'(1'b1));
      chk("t3_cnt", 145'(pkt_cnt), 145'(2'd1));
      step();

      // ---- 4: all-zero vectors, done three cycles after start -------------
      start = 1'b1; dual = 1'b1; addr = 8'h00;
      inval_vect0 = '0; inval_vect1 = '0;
      step();
      start = 1'b0;
      chk("t4_req_a", 145'(cpx_req), 145'(2'b00));
      chk("t4_done_a", 145'(done), 145'(1'b0));
      step();
      chk("t4_req_b", 145'(cpx_req), 145'(2'b00));
      chk("t4_done_b", 145'(done), 145'(1'b0));
      step();
      chk("t4_done", 145'(done), 145'(1'b1));
      chk("t4_cnt", 145'(pkt_cnt), 145'(2'd0));
      step();

      // ---- 5a: grant on the timeout cycle wins ----------------------------
      v0 = 112'd1 << 57;
      start = 1'b1; dual = 1'b0; addr = 8'h11; inval_vect0 = v0;
      step();
      start = 1'b0;
      step();                        // WAIT0, first wait cycle
      for (int i = 0; i < 7; i++) step();
      chk("t5a_req_pre", 145'(cpx_req), 145'(2'b01));
      cpx_grant = 2'b01;
      step();                        // 8th wait edge, grant present
      cpx_grant = 2'b00;
      chk("t5a_req", 145'(cpx_req), 145'(2'b00));
      chk("t5a_tmo", 145'(err_timeout), 145'(1'b0));
      step();
      chk("t5a_done", 145'(done), 145'(1'b1));
      chk("t5a_cnt", 145'(pkt_cnt), 145'(2'd1));
      step();

      // ---- 5b: no grant, timeout after 8 wait cycles ----------------------
      v0 = 112'd1 << 1;
      start = 1'b1; dual = 1'b0; addr = 8'h22; inval_vect0 = v0;
      step();
      start = 1'b0;
      step();                        // WAIT0
      for (int i = 0; i < 7; i++) step();
      chk("t5b_req_pre", 145'(cpx_req), 145'(2'b01));
      chk("t5b_tmo_pre", 145'(err_timeout), 145'(1'b0));
      step();
      chk("t5b_tmo", 145'(err_timeout), 145'(1'b1));
      chk("t5b_req", 145'(cpx_req), 145'(2'b00));
      chk("t5b_pkt", cpx_pkt, '0);
      step();
      chk("t5b_done", 145'(done), 145'(1'b1));
      chk("t5b_cnt", 145'(pkt_cnt), 145'(2'd0));
      step();
      chk("t5b_tmo_sticky", 145'(err_timeout), 145'(1'b1));

      // ---- 6: start while busy, two packets, both grants at once ----------
      v0 = 112'd1 << 5;
      v1 = 112'd1 << 56;
      start = 1'b1; dual = 1'b1; addr = 8'h77;
      inval_vect0 = v0; inval_vect1 = v1;
      step();                        // CHK0
      inval_vect0 = '0; inval_vect1 = '0; addr = 8'h00; dual = 1'b0;
      step();                        // WAIT0, second start dropped
      start = 1'b0;
      chk("t6_ovr", 145'(err_overrun), 145'(1'b1));
      chk("t6_req0", 145'(cpx_req), 145'(2'b10));
      chk("t6_pkt0", cpx_pkt, pkt(8'h77, v0));
      cpx_grant = 2'b10;
      step();                        // CHK1
      cpx_grant = 2'b00;
      step();                        // WAIT1
      chk("t6_req1", 145'(cpx_req), 145'(2'b01));
      chk("t6_pkt1", cpx_pkt, pkt(8'h77, v1));
      cpx_grant = 2'b11;
      step();                        // FIN
      cpx_grant = 2'b00;
      chk("t6_done", 145'(done), 145'(1'b1));
      chk("t6_cnt", 145'(pkt_cnt), 145'(2'd2));
      step();

      // ---- 7: asynchronous reset during WAIT0 -----------------------------
      v0 = 112'd1 << 32;
      start = 1'b1; dual = 1'b0; addr = 8'h99; inval_vect0 = v0;
      step();
      start = 1'b0;
      step();                        // WAIT0
      chk("t7_req_pre", 145'(cpx_req), 145'(2'b01));
      #2;
      reset = 1'b1;
      #1;
      chk("t7_req", 145'(cpx_req), 145'(2'b00));
      chk("t7_pkt", cpx_pkt, '0);
      chk("t7_busy", 145'(busy), 145'(1'b0));
      chk("t7_ovr", 145'(err_overrun), 145'(1'b0));
      chk("t7_tmo", 145'(err_timeout), 145'(1'b0));
      chk("t7_cnt", 145'(pkt_cnt), 145'(2'd0));
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t7_no_done", 145'(done), 145'(1'b0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
